// File: rtl/byteswap_burst_scheduler.sv
// Burst command scheduler for one byteswap kernel run: splits the buffer into
// 4 KB-safe read bursts, then re-issues each as an in-place write burst.
module byteswap_burst_scheduler #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_MAX_BURST_BEATS = 64,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic                         ap_clk,
  input  logic                         areset,
  input  logic                         ap_start,
  output logic                         ap_idle,
  output logic                         ap_done,
  output logic                         ap_ready,
  input  logic [C_ADDR_WIDTH-1:0]      gmem_ptr,
  input  logic [C_XFER_SIZE_WIDTH-1:0] xfer_size_bytes,
  output logic                         rd_cmd_valid,
  input  logic                         rd_cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]      rd_cmd_addr,
  output logic [7:0]                   rd_cmd_len,
  input  logic                         rd_burst_done,
  output logic                         wr_cmd_valid,
  input  logic                         wr_cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]      wr_cmd_addr,
  output logic [7:0]                   wr_cmd_len,
  input  logic                         wr_resp
);

  localparam int BEAT_BYTES = C_DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int PAGE_BEATS = 4096 / BEAT_BYTES;
  localparam int TB_W       = C_XFER_SIZE_WIDTH - 5;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [TB_W-1:0]         rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
  logic [CNT_W-1:0]        rd_out_q, rd_out_d, rd_avail_q, rd_avail_d, wr_out_q, wr_out_d;
  logic                    rd_cmd_valid_d, wr_cmd_valid_d, ap_idle_d, ap_done_d;
  logic [C_ADDR_WIDTH-1:0] rd_cmd_addr_d, wr_cmd_addr_d;
  logic [7:0]              rd_cmd_len_d, wr_cmd_len_d;
  logic [TB_W-1:0]         total_beats;
  logic [8:0]              rd_burst, wr_burst, first_burst, rd_hs_beats, wr_hs_beats;
  logic                    rd_hs, wr_hs;

  // Largest burst that stays inside the current 4 KB page and the burst cap.
  function automatic logic [8:0] burst_beats(input logic [11-BEAT_SHIFT:0] page_off,
                                             input logic [TB_W-1:0] rem);
    logic [8:0] b;
    b = 9'(PAGE_BEATS) - 9'(page_off);
    if (b > 9'(C_MAX_BURST_BEATS)) b = 9'(C_MAX_BURST_BEATS);
    if (TB_W'(b) > rem) b = 9'(rem);
    return b;
  endfunction

  // Up/down counter that cancels simultaneous events and never wraps below 0.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    if (inc && !dec) return c + CNT_W'(1);
    if (dec && !inc && c != '0) return c - CNT_W'(1);
    return c;
  endfunction

  assign total_beats = TB_W'(({1'b0, xfer_size_bytes} +
                              (C_XFER_SIZE_WIDTH+1)'(BEAT_BYTES-1)) >> BEAT_SHIFT);
  assign first_burst = burst_beats(gmem_ptr[11:BEAT_SHIFT], total_beats);
  assign rd_burst    = burst_beats(rd_addr_q[11:BEAT_SHIFT], rd_rem_q);
  assign wr_burst    = burst_beats(wr_addr_q[11:BEAT_SHIFT], wr_rem_q);
  assign rd_hs       = rd_cmd_valid & rd_cmd_ready;
  assign wr_hs       = wr_cmd_valid & wr_cmd_ready;
  assign rd_hs_beats = {1'b0, rd_cmd_len} + 9'd1;
  assign wr_hs_beats = {1'b0, wr_cmd_len} + 9'd1;

  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_addr_q;
    rd_rem_d       = rd_rem_q;
    wr_rem_d       = wr_rem_q;
    rd_out_d       = rd_out_q;
    rd_avail_d     = rd_avail_q;
    wr_out_d       = wr_out_q;
    rd_cmd_valid_d = rd_cmd_valid;
    rd_cmd_addr_d  = rd_cmd_addr;
    rd_cmd_len_d   = rd_cmd_len;
    wr_cmd_valid_d = wr_cmd_valid;
    wr_cmd_addr_d  = wr_cmd_addr;
    wr_cmd_len_d   = wr_cmd_len;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d    = RUN;
          rd_addr_d  = gmem_ptr;
          wr_addr_d  = gmem_ptr;
          rd_rem_d   = total_beats;
          wr_rem_d   = total_beats;
          rd_out_d   = '0;
          rd_avail_d = '0;
          wr_out_d   = '0;
          // First read command is staged here so it is visible on the first RUN cycle.
          if (total_beats != '0) begin
            rd_cmd_valid_d = 1'b1;
            rd_cmd_addr_d  = gmem_ptr;
            rd_cmd_len_d   = 8'(first_burst - 9'd1);
          end
        end
      end
      RUN: begin
        rd_out_d   = sat_step(rd_out_q, rd_hs, rd_burst_done);
        rd_avail_d = sat_step(rd_avail_q, rd_burst_done, wr_hs);
        wr_out_d   = sat_step(wr_out_q, wr_hs, wr_resp);
        if (rd_hs) begin
          rd_cmd_valid_d = 1'b0;
          rd_addr_d      = rd_addr_q + (C_ADDR_WIDTH'(rd_hs_beats) << BEAT_SHIFT);
          rd_rem_d       = rd_rem_q - TB_W'(rd_hs_beats);
        end else if (!rd_cmd_valid && rd_rem_q != '0 &&
                     ({1'b0, rd_out_q} + {1'b0, rd_avail_q}) < (CNT_W+1)'(C_MAX_OUTSTANDING)) begin
          rd_cmd_valid_d = 1'b1;
          rd_cmd_addr_d  = rd_addr_q;
          rd_cmd_len_d   = 8'(rd_burst - 9'd1);
        end
        if (wr_hs) begin
          wr_cmd_valid_d = 1'b0;
          wr_addr_d      = wr_addr_q + (C_ADDR_WIDTH'(wr_hs_beats) << BEAT_SHIFT);
          wr_rem_d       = wr_rem_q - TB_W'(wr_hs_beats);
        end else if (!wr_cmd_valid && rd_avail_q != '0 && wr_rem_q != '0) begin
          wr_cmd_valid_d = 1'b1;
          wr_cmd_addr_d  = wr_addr_q;
          wr_cmd_len_d   = 8'(wr_burst - 9'd1);
        end
        // Exit on next-state values so ap_done follows the final wr_resp by one cycle.
        if (rd_rem_d == '0 && wr_rem_d == '0 && rd_out_d == '0 &&
            rd_avail_d == '0 && wr_out_d == '0)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ap_idle_d = (state_d == IDLE);
    ap_done_d = (state_d == DONE);
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      rd_rem_q     <= '0;
      wr_rem_q     <= '0;
      rd_out_q     <= '0;
      rd_avail_q   <= '0;
      wr_out_q     <= '0;
      rd_cmd_valid <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_len   <= '0;
      wr_cmd_valid <= 1'b0;
      wr_cmd_addr  <= '0;
      wr_cmd_len   <= '0;
      ap_idle      <= 1'b1;
      ap_done      <= 1'b0;
      ap_ready     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      rd_rem_q     <= rd_rem_d;
      wr_rem_q     <= wr_rem_d;
      rd_out_q     <= rd_out_d;
      rd_avail_q   <= rd_avail_d;
      wr_out_q     <= wr_out_d;
      rd_cmd_valid <= rd_cmd_valid_d;
      rd_cmd_addr  <= rd_cmd_addr_d;
      rd_cmd_len   <= rd_cmd_len_d;
      wr_cmd_valid <= wr_cmd_valid_d;
      wr_cmd_addr  <= wr_cmd_addr_d;
      wr_cmd_len   <= wr_cmd_len_d;
      ap_idle      <= ap_idle_d;
      ap_done      <= ap_done_d;
      ap_ready     <= ap_done_d;
    end
  end

endmodule

// File: tb/tb_byteswap_burst_scheduler.sv
// Scoreboard bench for byteswap_burst_scheduler: expected commands are queued
// by the stimulus, a negedge monitor pops and compares on each handshake.
module tb_byteswap_burst_scheduler;

  logic        ap_clk = 1'b0;
  logic        areset, ap_start, ap_idle, ap_done, ap_ready;
  logic [63:0] gmem_ptr;
  logic [31:0] xfer_size_bytes;
  logic        rd_cmd_valid, rd_cmd_ready, rd_burst_done;
  logic [63:0] rd_cmd_addr;
  logic [7:0]  rd_cmd_len;
  logic        wr_cmd_valid, wr_cmd_ready, wr_resp;
  logic [63:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_len;

  byteswap_burst_scheduler dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .ap_ready(ap_ready), .gmem_ptr(gmem_ptr),
    .xfer_size_bytes(xfer_size_bytes),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len), .rd_burst_done(rd_burst_done),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_resp(wr_resp)
  );

  always #5 ap_clk = ~ap_clk;

  int          checks = 0, errors = 0;
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0;
  int          last_wr_resp_cyc = 0, manual_rd = 0;
  logic        auto_resp = 1'b0;
  logic [71:0] exp_rd[$], exp_wr[$];
  int          rd_due[$], wr_due[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [63:0] a, input logic [7:0] l);
    exp_rd.push_back({a, l});
  endtask

  task automatic push_wr(input logic [63:0] a, input logic [7:0] l);
    exp_wr.push_back({a, l});
  endtask

  // Monitor: outputs settle after posedge, inputs change at posedge+1.
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge ap_clk);
      if (!areset) begin
        chk("ready_eq_done", 72'(ap_ready), 72'(ap_done));
        if (rd_cmd_valid && rd_cmd_ready) begin
          rd_cnt++;
          if (exp_rd.size() == 0) chk("rd_unexpected", {rd_cmd_addr, rd_cmd_len}, 72'h0);
          else begin
            e = exp_rd.pop_front();
            chk("rd_cmd", {rd_cmd_addr, rd_cmd_len}, e);
          end
          if (auto_resp) rd_due.push_back(cyc + 10);
        end
        if (wr_cmd_valid && wr_cmd_ready) begin
          wr_cnt++;
          if (exp_wr.size() == 0) chk("wr_unexpected", {wr_cmd_addr, wr_cmd_len}, 72'h0);
          else begin
            e = exp_wr.pop_front();
            chk("wr_cmd", {wr_cmd_addr, wr_cmd_len}, e);
          end
          if (auto_resp) wr_due.push_back(cyc + 5);
        end
        if (ap_done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_not_idle", 72'(ap_idle), 72'h0);
        end
      end
    end
  end

  // Responder: returns rd_burst_done/wr_resp pulses at their scheduled cycles.
  initial begin
    rd_burst_done = 1'b0;
    wr_resp       = 1'b0;
    forever begin
      @(posedge ap_clk); #1;
      cyc++;
      rd_burst_done = 1'b0;
      wr_resp       = 1'b0;
      if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
        rd_due.delete(0);
        rd_burst_done = 1'b1;
      end else if (manual_rd > 0) begin
        manual_rd--;
        rd_burst_done = 1'b1;
      end
      if (wr_due.size() > 0 && wr_due[0] <= cyc) begin
        wr_due.delete(0);
        wr_resp          = 1'b1;
        last_wr_resp_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge ap_clk); #1; end
  endtask

  task automatic start_run(input logic [63:0] ptr, input logic [31:0] size);
    tick(1);
    gmem_ptr        = ptr;
    xfer_size_bytes = size;
    ap_start        = 1'b1;
    tick(1);
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int n0, input int budget);
    int k = 0;
    while (done_cnt == n0 && k < budget) begin tick(1); k++; end
    chk({nm, "_done"}, 72'(done_cnt), 72'(n0 + 1));
  endtask

  task automatic full_run(input string nm, input logic [63:0] ptr, input logic [31:0] size);
    int n0 = done_cnt;
    start_run(ptr, size);
    wait_done(nm, n0, 400);
    chk({nm, "_done_lat"}, 72'(done_cyc), 72'(last_wr_resp_cyc + 1));
    chk({nm, "_all_seen"}, 72'(exp_rd.size() + exp_wr.size()), 72'h0);
    tick(4);
    chk({nm, "_single_done"}, 72'(done_cnt), 72'(n0 + 1));
    chk({nm, "_idle_after"}, 72'(ap_idle), 72'h1);
  endtask

  task automatic flush();
    exp_rd.delete(); exp_wr.delete(); rd_due.delete(); wr_due.delete();
    manual_rd = 0;
  endtask

  initial begin
    int n0, r0, w0, k, unstable;
    logic [63:0] cap_addr;
    logic [7:0]  cap_len;
    areset = 1'b1; ap_start = 1'b0; gmem_ptr = '0; xfer_size_bytes = '0;
    rd_cmd_ready = 1'b1; wr_cmd_ready = 1'b1;
    tick(3);
    chk("rst_idle", 72'(ap_idle), 72'h1);
    chk("rst_done", {70'h0, ap_done, ap_ready}, 72'h0);
    chk("rst_valids", {70'h0, rd_cmd_valid, wr_cmd_valid}, 72'h0);
    chk("rst_rd_cmd", {rd_cmd_addr, rd_cmd_len}, 72'h0);
    chk("rst_wr_cmd", {wr_cmd_addr, wr_cmd_len}, 72'h0);
    areset = 1'b0;
    tick(2);

    // Two full 4 KB bursts
    auto_resp = 1'b1;
    push_rd(64'h1000, 8'd63); push_rd(64'h2000, 8'd63);
    push_wr(64'h1000, 8'd63); push_wr(64'h2000, 8'd63);
    full_run("t1", 64'h1000, 32'd8192);

    // 4 KB boundary split: one beat below the page, three above
    push_rd(64'h0FC0, 8'd0); push_rd(64'h1000, 8'd2);
    push_wr(64'h0FC0, 8'd0); push_wr(64'h1000, 8'd2);
    full_run("t2", 64'h0FC0, 32'd256);

    // Partial beat rounds up
    push_rd(64'h40000, 8'd1); push_wr(64'h40000, 8'd1);
    full_run("t3", 64'h40000, 32'd100);

    // Zero length: done two cycles after start, no commands
    r0 = rd_cnt; w0 = wr_cnt; n0 = done_cnt;
    tick(1);
    gmem_ptr = 64'h5000; xfer_size_bytes = 32'd0; ap_start = 1'b1;
    tick(1);
    ap_start = 1'b0;
    chk("t4_t1_state", {69'h0, ap_idle, ap_done, ap_ready}, 72'h0);
    tick(1);
    chk("t4_t2_done", {69'h0, ap_idle, ap_done, ap_ready}, 72'h3);
    tick(1);
    chk("t4_t3_idle", {69'h0, ap_idle, ap_done, ap_ready}, 72'h4);
    tick(3);
    chk("t4_no_cmds", 72'(rd_cnt - r0 + wr_cnt - w0), 72'h0);
    chk("t4_one_done", 72'(done_cnt), 72'(n0 + 1));

    // Outstanding limit: four reads, then one more only after a write retires a slot
    auto_resp = 1'b0;
    r0 = rd_cnt; w0 = wr_cnt;
    push_rd(64'h0, 8'd63); push_rd(64'h1000, 8'd63); push_rd(64'h2000, 8'd63);
    push_rd(64'h3000, 8'd63); push_rd(64'h4000, 8'd63);
    push_wr(64'h0, 8'd63);
    start_run(64'h0, 32'd65536);
    tick(40);
    chk("t5_rd_capped", 72'(rd_cnt - r0), 72'd4);
    chk("t5_no_wr", 72'(wr_cnt - w0), 72'd0);
    chk("t5_rd_valid_low", 72'(rd_cmd_valid), 72'h0);
    manual_rd = 1;
    tick(30);
    chk("t5_rd_after", 72'(rd_cnt - r0), 72'd5);
    chk("t5_wr_after", 72'(wr_cnt - w0), 72'd1);
    chk("t5_all_seen", 72'(exp_rd.size() + exp_wr.size()), 72'h0);
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    chk("t5_abort_idle", {69'h0, ap_idle, rd_cmd_valid, wr_cmd_valid}, 72'h4);
    flush();
    tick(2);

    // Backpressure hold and ap_start ignored while running
    auto_resp = 1'b1;
    rd_cmd_ready = 1'b0;
    n0 = done_cnt;
    push_rd(64'h8000, 8'd1); push_wr(64'h8000, 8'd1);
    start_run(64'h8000, 32'd128);
    k = 0;
    while (!rd_cmd_valid && k < 10) begin tick(1); k++; end
    chk("t6_valid_seen", 72'(rd_cmd_valid), 72'h1);
    cap_addr = rd_cmd_addr; cap_len = rd_cmd_len; unstable = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      ap_start = (i == 10);
      if (rd_cmd_valid !== 1'b1 || rd_cmd_addr !== cap_addr || rd_cmd_len !== cap_len)
        unstable++;
    end
    ap_start = 1'b0;
    chk("t6_stable", 72'(unstable), 72'h0);
    chk("t6_held_cmd", {cap_addr, cap_len}, {64'h8000, 8'd1});
    rd_cmd_ready = 1'b1;
    wait_done("t6", n0, 200);
    tick(10);
    chk("t6_start_ignored", 72'(done_cnt), 72'(n0 + 1));

    // Reset mid-run with two reads outstanding, then a clean run
    auto_resp = 1'b0;
    r0 = rd_cnt; n0 = done_cnt;
    push_rd(64'h10000, 8'd63); push_rd(64'h11000, 8'd63);
    start_run(64'h10000, 32'd16384);
    k = 0;
    while (rd_cnt - r0 < 2 && k < 50) begin tick(1); k++; end
    rd_cmd_ready = 1'b0;
    chk("t7_two_out", 72'(rd_cnt - r0), 72'd2);
    tick(3);
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    chk("t7_abort", {68'h0, ap_idle, ap_done, rd_cmd_valid, wr_cmd_valid}, 72'h8);
    tick(5);
    chk("t7_no_done", 72'(done_cnt), 72'(n0));
    flush();
    rd_cmd_ready = 1'b1;
    auto_resp = 1'b1;
    push_rd(64'h20040, 8'd1); push_wr(64'h20040, 8'd1);
    full_run("t7_rerun", 64'h20040, 32'd128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
